// File: rtl/simon_sequencer_pkg.sv
// simon_sequencer_pkg: shared widths, tile codes, FSM state encoding and helpers for the Simon sequencer
package simon_sequencer_pkg;
  localparam int TILE_W  = 2;
  localparam int LEVEL_W = 5;
  localparam logic [TILE_W-1:0] T0 = 2'd0;
  localparam logic [TILE_W-1:0] T1 = 2'd1;
  localparam logic [TILE_W-1:0] T2 = 2'd2;
  localparam logic [TILE_W-1:0] T3 = 2'd3;
  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_EXTEND,
    S_PB_FLASH, S_PB_HOLD, S_PB_RESTORE, S_PB_GAP,
    S_INPUT, S_IN_FLASH, S_IN_RESTORE, S_CHECK,
    S_WIN, S_LOSE
  } state_e;
  function automatic logic is_draw(state_e s);
    return s inside {S_PB_FLASH, S_PB_RESTORE, S_IN_FLASH, S_IN_RESTORE};
  endfunction
  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/simon_sequencer_timer.sv
// simon_sequencer_timer: loadable down-counter that parks at zero; shared by hold, gap and input timeout
module simon_sequencer_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [W-1:0] load_val_i,
  input  logic         load_i,
  input  logic         en_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // load has priority; counting stops at zero
  always_comb cnt_d = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  // count register
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/simon_sequencer.sv
// simon_sequencer: Simon game scheduler issuing flash/restore draw jobs; SIMON_TIMEOUT_EN adds an input timeout
module simon_sequencer
  import simon_sequencer_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned FLASH_CYCLES   = 12_500_000,
  parameter int unsigned GAP_CYCLES     = 6_250_000,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [TILE_W-1:0]  rnd_tile,
  input  logic               key_valid,
  input  logic [TILE_W-1:0]  key_tile,
  output logic               draw_req,
  output logic [TILE_W-1:0]  draw_tile,
  output logic               draw_flash,
  input  logic               draw_done,
  output logic [LEVEL_W-1:0] level,
  output logic               busy,
  output logic               win,
  output logic               game_over
);
`ifdef SIMON_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam int IDX_W = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam int CNT_W = $clog2(max3(FLASH_CYCLES, GAP_CYCLES, TIMEOUT_EN ? TIMEOUT_CYCLES : 1) + 1);
  state_e              state_q, state_d;
  logic [LEVEL_W-1:0]  level_q, level_d, idx_q, idx_d;
  logic [TILE_W-1:0]   key_q, key_d, cur_tile;
  logic [TILE_W-1:0]   mem_q [MAX_LEN];
  logic                req_q, req_d, mem_we, done_ok, last;
  logic                tmr_load, tmr_en, tmr_zero;
  logic [CNT_W-1:0]    tmr_val;
  assign cur_tile = mem_q[idx_q[IDX_W-1:0]];
  assign last     = idx_q == level_q - LEVEL_W'(1);
  assign done_ok  = req_q && draw_done;
  // next-state and datapath updates
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    idx_d   = idx_q;
    key_d   = key_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: state_d = start ? S_CLEAR : state_q;
      S_CLEAR: begin
        level_d = '0;
        state_d = S_EXTEND;
      end
      S_EXTEND: begin
        mem_we  = 1'b1;
        level_d = level_q + LEVEL_W'(1);
        idx_d   = '0;
        state_d = S_PB_FLASH;
      end
      S_PB_FLASH:   state_d = done_ok ? S_PB_HOLD : state_q;
      S_PB_HOLD:    state_d = tmr_zero ? S_PB_RESTORE : state_q;
      S_PB_RESTORE: state_d = done_ok ? S_PB_GAP : state_q;
      S_PB_GAP: if (tmr_zero) begin
        state_d = last ? S_INPUT : S_PB_FLASH;
        idx_d   = last ? '0 : idx_q + LEVEL_W'(1);
      end
      S_INPUT: if (key_valid) begin
        key_d   = key_tile;
        state_d = S_IN_FLASH;
      end else if (TIMEOUT_EN && tmr_zero) state_d = S_LOSE;
      S_IN_FLASH:   state_d = done_ok ? S_IN_RESTORE : state_q;
      S_IN_RESTORE: state_d = done_ok ? S_CHECK : state_q;
      S_CHECK: begin
        state_d = key_q != cur_tile ? S_LOSE : !last ? S_INPUT : level_q == LEVEL_W'(MAX_LEN) ? S_WIN : S_EXTEND;
        idx_d   = (key_q == cur_tile && !last) ? idx_q + LEVEL_W'(1) : idx_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // a job that just completed always drops req for a cycle, so consecutive jobs are separated
  assign req_d    = is_draw(state_d) && !done_ok;
  assign tmr_load = state_d != state_q &&
                    (state_d == S_PB_HOLD || state_d == S_PB_GAP || (TIMEOUT_EN && state_d == S_INPUT));
  assign tmr_en   = state_q == S_PB_HOLD || state_q == S_PB_GAP || (TIMEOUT_EN && state_q == S_INPUT);
  assign tmr_val  = state_d == S_PB_GAP ? CNT_W'(GAP_CYCLES - 1) :
                    (TIMEOUT_EN && state_d == S_INPUT) ? CNT_W'(TIMEOUT_CYCLES - 1) : CNT_W'(FLASH_CYCLES - 1);
  simon_sequencer_timer #(.W(CNT_W)) u_timer (
    .clock     (clock),
    .resetn    (resetn),
    .load_val_i(tmr_val),
    .load_i    (tmr_load),
    .en_i      (tmr_en),
    .zero_o    (tmr_zero)
  );
  // state, level, index, latched key and request registers
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state_q <= S_IDLE;
      level_q <= '0;
      idx_q   <= '0;
      key_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      req_q   <= req_d;
    end
  // pattern memory keeps its contents across reset
  always_ff @(posedge clock)
    if (mem_we) mem_q[level_q[IDX_W-1:0]] <= rnd_tile;
  assign draw_req   = req_q;
  assign draw_tile  = (state_q == S_PB_FLASH || state_q == S_PB_RESTORE) ? cur_tile :
                      (state_q == S_IN_FLASH || state_q == S_IN_RESTORE) ? key_q : T0;
  assign draw_flash = state_q == S_PB_FLASH || state_q == S_IN_FLASH;
  assign level      = level_q;
  assign busy       = !(state_q inside {S_IDLE, S_INPUT, S_WIN, S_LOSE});
  assign win        = state_q == S_WIN;
  assign game_over  = state_q == S_LOSE;
endmodule

// File: tb/tb_simon_sequencer.sv
// tb_simon_sequencer: directed bench with a one-cycle-latency graphics slave logging every draw job
module tb_simon_sequencer;
  import simon_sequencer_pkg::*;
  localparam int FLASH = 4;
  localparam int GAP   = 2;
  logic       clock = 0, resetn = 0, start = 0, key_valid = 0, draw_done = 0;
  logic [1:0] rnd_tile = 0, key_tile = 0, draw_tile;
  logic       draw_req, draw_flash, busy, win, game_over;
  logic [4:0] level;
  int vectors = 0, errs = 0, cyc = 0;
  typedef struct {logic [1:0] tile; logic flash; int cyc;} job_t;
  job_t jobs[$];

  simon_sequencer #(.MAX_LEN(3), .FLASH_CYCLES(FLASH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(20)) dut (
    .clock(clock), .resetn(resetn), .start(start), .rnd_tile(rnd_tile),
    .key_valid(key_valid), .key_tile(key_tile),
    .draw_req(draw_req), .draw_tile(draw_tile), .draw_flash(draw_flash), .draw_done(draw_done),
    .level(level), .busy(busy), .win(win), .game_over(game_over)
  );

  always #5 clock = ~clock;

  always begin
    @(posedge clock);
    cyc++;
    #1;
    if (draw_req && !draw_done) begin
      jobs.push_back('{tile: draw_tile, flash: draw_flash, cyc: cyc});
      draw_done = 1;
    end else draw_done = 0;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [1:0] rnd);
    rnd_tile = rnd;
    start = 1;
    @(negedge clock);
    start = 0;
  endtask

  task automatic press(input logic [1:0] t);
    key_tile = t;
    key_valid = 1;
    @(negedge clock);
    key_valid = 0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL %s wait: busy=%b after %0d cycles, want 0", tag, busy, n);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    vectors += 6;
    if (draw_req !== 1'b0) begin errs++; $display("FAIL reset draw_req: got %b want 0", draw_req); end
    if (level !== 5'd0) begin errs++; $display("FAIL reset level: got %0d want 0", level); end
    if (busy !== 1'b0) begin errs++; $display("FAIL reset busy: got %b want 0", busy); end
    if (win !== 1'b0) begin errs++; $display("FAIL reset win: got %b want 0", win); end
    if (game_over !== 1'b0) begin errs++; $display("FAIL reset game_over: got %b want 0", game_over); end
    if ({draw_tile, draw_flash} !== 3'b000) begin errs++; $display("FAIL reset draw_tile/flash: got %b want 000", {draw_tile, draw_flash}); end
    resetn = 1;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_job;
    int n = 0;
    jobs.delete();
    pulse_start(T2);
    while (!(jobs.size() == 1 && !draw_req) && n < 50) begin
      @(negedge clock);
      n++;
    end
    vectors += 2;
    if (busy !== 1'b1) begin errs++; $display("FAIL hold busy: got %b want 1", busy); end
    if (level !== 5'd1) begin errs++; $display("FAIL hold level: got %0d want 1", level); end
    #2 resetn = 0;
    #1;
    vectors += 3;
    if (draw_req !== 1'b0) begin errs++; $display("FAIL async reset draw_req: got %b want 0", draw_req); end
    if (busy !== 1'b0) begin errs++; $display("FAIL async reset busy: got %b want 0", busy); end
    if (level !== 5'd0) begin errs++; $display("FAIL async reset level: got %0d want 0", level); end
    @(negedge clock);
    vectors += 2;
    if (busy !== 1'b0) begin errs++; $display("FAIL reset next cycle busy: got %b want 0", busy); end
    if (draw_req !== 1'b0) begin errs++; $display("FAIL reset next cycle draw_req: got %b want 0", draw_req); end
    resetn = 1;
    @(negedge clock);
    pulse_start(T1);
    n = 0;
    while (!draw_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (draw_req !== 1'b1) begin errs++; $display("FAIL req before reset: got %b want 1", draw_req); end
    #1 resetn = 0;
    #1;
    vectors++;
    if (draw_req !== 1'b0) begin errs++; $display("FAIL async drop of active req: got %b want 0", draw_req); end
    @(negedge clock);
    resetn = 1;
    @(negedge clock);
  endtask

  task automatic test_first_round;
    logic [2:0] want [2] = '{3'b101, 3'b100};
    logic [2:0] got;
    jobs.delete();
    pulse_start(T2);
    wait_ready("first round");
    vectors++;
    if (jobs.size() != 2) begin errs++; $display("FAIL round1 job count: got %0d want 2", jobs.size()); end
    foreach (want[i]) begin
      got = i < jobs.size() ? {jobs[i].tile, jobs[i].flash} : 3'bxxx;
      vectors++;
      if (got !== want[i]) begin errs++; $display("FAIL round1 job%0d tile/flash: got %b want %b", i, got, want[i]); end
    end
    if (jobs.size() == 2) begin
      vectors += 2;
      if (jobs[1].cyc - jobs[0].cyc != FLASH + 1) begin errs++; $display("FAIL round1 hold spacing: got %0d want %0d", jobs[1].cyc - jobs[0].cyc, FLASH + 1); end
      if (cyc - jobs[1].cyc != GAP + 1) begin errs++; $display("FAIL round1 gap to input: got %0d want %0d", cyc - jobs[1].cyc, GAP + 1); end
    end
    vectors += 3;
    if (level !== 5'd1) begin errs++; $display("FAIL round1 level: got %0d want 1", level); end
    if (game_over !== 1'b0) begin errs++; $display("FAIL round1 game_over: got %b want 0", game_over); end
    if (win !== 1'b0) begin errs++; $display("FAIL round1 win: got %b want 0", win); end
  endtask

  task automatic test_extend;
    logic [2:0] want [6] = '{3'b101, 3'b100, 3'b101, 3'b100, 3'b001, 3'b000};
    logic [2:0] got;
    jobs.delete();
    rnd_tile = T0;
    press(T2);
    wait_ready("extend");
    vectors++;
    if (jobs.size() != 6) begin errs++; $display("FAIL extend job count: got %0d want 6", jobs.size()); end
    foreach (want[i]) begin
      got = i < jobs.size() ? {jobs[i].tile, jobs[i].flash} : 3'bxxx;
      vectors++;
      if (got !== want[i]) begin errs++; $display("FAIL extend job%0d tile/flash: got %b want %b", i, got, want[i]); end
    end
    if (jobs.size() == 6) begin
      vectors += 3;
      if (jobs[1].cyc - jobs[0].cyc != 2) begin errs++; $display("FAIL echo spacing: got %0d want 2", jobs[1].cyc - jobs[0].cyc); end
      if (jobs[3].cyc - jobs[2].cyc != FLASH + 1) begin errs++; $display("FAIL extend hold spacing: got %0d want %0d", jobs[3].cyc - jobs[2].cyc, FLASH + 1); end
      if (jobs[4].cyc - jobs[3].cyc != GAP + 1) begin errs++; $display("FAIL extend gap spacing: got %0d want %0d", jobs[4].cyc - jobs[3].cyc, GAP + 1); end
    end
    vectors++;
    if (level !== 5'd2) begin errs++; $display("FAIL extend level: got %0d want 2", level); end
  endtask

  task automatic test_lose;
    logic [2:0] want [4] = '{3'b101, 3'b100, 3'b111, 3'b110};
    logic [2:0] got;
    jobs.delete();
    press(T2);
    wait_ready("lose first key");
    vectors++;
    if (game_over !== 1'b0) begin errs++; $display("FAIL lose after good key game_over: got %b want 0", game_over); end
    press(T3);
    wait_ready("lose second key");
    vectors++;
    if (jobs.size() != 4) begin errs++; $display("FAIL lose job count: got %0d want 4", jobs.size()); end
    foreach (want[i]) begin
      got = i < jobs.size() ? {jobs[i].tile, jobs[i].flash} : 3'bxxx;
      vectors++;
      if (got !== want[i]) begin errs++; $display("FAIL lose job%0d tile/flash: got %b want %b", i, got, want[i]); end
    end
    vectors += 3;
    if (game_over !== 1'b1) begin errs++; $display("FAIL lose game_over: got %b want 1", game_over); end
    if (level !== 5'd2) begin errs++; $display("FAIL lose level: got %0d want 2", level); end
    if (win !== 1'b0) begin errs++; $display("FAIL lose win: got %b want 0", win); end
    press(T1);
    repeat (5) @(negedge clock);
    vectors += 3;
    if (jobs.size() != 4) begin errs++; $display("FAIL key after lose jobs: got %0d want 4", jobs.size()); end
    if (game_over !== 1'b1) begin errs++; $display("FAIL key after lose game_over: got %b want 1", game_over); end
    if (busy !== 1'b0) begin errs++; $display("FAIL key after lose busy: got %b want 0", busy); end
  endtask

  task automatic test_win;
    logic [2:0] want [6] = '{3'b011, 3'b010, 3'b011, 3'b010, 3'b111, 3'b110};
    logic [2:0] got;
    pulse_start(T1);
    wait_ready("win round1");
    vectors++;
    if (level !== 5'd1) begin errs++; $display("FAIL win round1 level: got %0d want 1", level); end
    jobs.delete();
    rnd_tile = T3;
    press(T1);
    start = 1;
    @(negedge clock);
    start = 0;
    press(T0);
    wait_ready("win round2");
    vectors++;
    if (jobs.size() != 6) begin errs++; $display("FAIL win round2 job count: got %0d want 6", jobs.size()); end
    foreach (want[i]) begin
      got = i < jobs.size() ? {jobs[i].tile, jobs[i].flash} : 3'bxxx;
      vectors++;
      if (got !== want[i]) begin errs++; $display("FAIL win round2 job%0d tile/flash: got %b want %b", i, got, want[i]); end
    end
    vectors++;
    if (level !== 5'd2) begin errs++; $display("FAIL win round2 level: got %0d want 2", level); end
    rnd_tile = T0;
    press(T1);
    wait_ready("win r2k1");
    press(T3);
    wait_ready("win r2k2");
    vectors++;
    if (level !== 5'd3) begin errs++; $display("FAIL win round3 level: got %0d want 3", level); end
    press(T1);
    wait_ready("win r3k1");
    press(T3);
    wait_ready("win r3k2");
    press(T0);
    wait_ready("win r3k3");
    vectors += 4;
    if (win !== 1'b1) begin errs++; $display("FAIL win flag: got %b want 1", win); end
    if (level !== 5'd3) begin errs++; $display("FAIL win level: got %0d want 3", level); end
    if (game_over !== 1'b0) begin errs++; $display("FAIL win game_over: got %b want 0", game_over); end
    if (busy !== 1'b0) begin errs++; $display("FAIL win busy: got %b want 0", busy); end
    pulse_start(T2);
    vectors++;
    if (win !== 1'b0) begin errs++; $display("FAIL restart win: got %b want 0", win); end
    wait_ready("restart");
    vectors += 2;
    if (level !== 5'd1) begin errs++; $display("FAIL restart level: got %0d want 1", level); end
    if (win !== 1'b0) begin errs++; $display("FAIL restart win after playback: got %b want 0", win); end
  endtask

`ifdef SIMON_TIMEOUT_EN
  task automatic test_timeout;
    int n = 0;
    while (!game_over && n < 100) begin
      @(negedge clock);
      n++;
    end
    vectors += 2;
    if (game_over !== 1'b1) begin errs++; $display("FAIL timeout game_over: got %b want 1", game_over); end
    if (n != 20) begin errs++; $display("FAIL timeout cycles: got %0d want 20", n); end
    pulse_start(T2);
    wait_ready("timeout restart");
    repeat (19) @(negedge clock);
    press(T2);
    wait_ready("timeout last-cycle key");
    vectors += 2;
    if (game_over !== 1'b0) begin errs++; $display("FAIL key on expiry game_over: got %b want 0", game_over); end
    if (level !== 5'd2) begin errs++; $display("FAIL key on expiry level: got %0d want 2", level); end
  endtask
`endif

  initial begin
    test_reset;
    test_reset_mid_job;
    test_first_round;
    test_extend;
    test_lose;
    test_win;
`ifdef SIMON_TIMEOUT_EN
    test_timeout;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
